sd_cmd_transaction: RTL and testbench

- Command-transaction stage directly upstream of the SD CMD physical layer.
- Accepts a host command request (index plus 32-bit argument) and builds the 40-bit CMD frame.
- Delivers the frame to the physical layer with a 4-phase strobe/ack handshake, then collects the 15-bit response or a timeout.
- Reports completion or error to the host side and guards against a hung physical layer with its own watchdog.

---
 rtl/sd_cmd_pkg.sv | 33 +++
 rtl/cmd_timeout_counter.sv | 42 ++++
 rtl/sd_cmd_transaction.sv | 197 +++++++++++++++++++
 tb/tb_sd_cmd_transaction.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_pkg.sv
// ----------------------------------------------------------------------------
// sd_cmd_pkg
// Shared definitions for the SD CMD transaction stage: the FSM state
// encoding, frame/response widths, the fixed frame header bits and a helper
// that assembles a 40-bit CMD frame from an index and an argument.
// ----------------------------------------------------------------------------
package sd_cmd_pkg;

    localparam int FRAME_W = 40;
    localparam int RESP_W  = 15;

    localparam logic START_BIT = 1'b0;
    localparam logic TX_BIT    = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        RELEASE   = 3'd2,
        WAIT_RESP = 3'd3,
        ACK_RESP  = 3'd4,
        DONE      = 3'd5,
        FAIL      = 3'd6
    } state_t;

    // Frame layout, MSB first: start bit, transmission bit, index, argument.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [5:0]  idx,
        input logic [31:0] arg
    );
        return {START_BIT, TX_BIT, idx, arg};
    endfunction

endpackage

// File: rtl/cmd_timeout_counter.sv
// ----------------------------------------------------------------------------
// cmd_timeout_counter
// Saturating watchdog counter. Counts while enabled, never wraps, and flags
// expiry once the count reaches TIMEOUT_CYCLES-1.
// Ports:
//   i_clk      clock, rising edge
//   i_reset    synchronous active-high reset
//   i_clear    return the count to zero (takes priority over i_enable)
//   i_enable   advance the count by one this cycle
//   o_expired  count has reached TIMEOUT_CYCLES-1
// ----------------------------------------------------------------------------
module cmd_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES <= 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Watchdog count: clear has priority, then saturating increment.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_clear) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/sd_cmd_transaction.sv
// ----------------------------------------------------------------------------
// sd_cmd_transaction
// Command-transaction stage in front of the SD CMD physical layer. Captures a
// host request, hands the 40-bit frame to the PHY with a 4-phase strobe/ack
// handshake, collects the 15-bit response (or a timeout) and reports
// completion or error. A local watchdog bounds every wait state.
// Optional build macro: CMD_RETRY_EN -- a response timeout is re-sent up to
// MAX_RETRIES times before an error is reported.
// Ports:
//   sd_clock, reset            clock (rising edge), synchronous active-high reset
//   new_command, cmd_index,
//   cmd_argument,
//   no_response_req            host request, captured only in IDLE
//   busy, command_complete,
//   timeout_error, idle_out    host-side status (pulses are one cycle)
//   response_out               last received response
//   cmd_to_send, strobe_out,
//   ack_in                     frame handshake to the PHY
//   no_response_out            registered no-response flag for the PHY
//   strobe_in, ack_out,
//   response_in                response handshake from the PHY
//   command_timeout_in         PHY-side response timeout
// ----------------------------------------------------------------------------
module sd_cmd_transaction
    import sd_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRIES    = 2
) (
    input  logic               sd_clock,
    input  logic               reset,
    input  logic               new_command,
    input  logic [5:0]         cmd_index,
    input  logic [31:0]        cmd_argument,
    input  logic               no_response_req,
    output logic               busy,
    output logic               command_complete,
    output logic               timeout_error,
    output logic [RESP_W-1:0]  response_out,
    output logic [FRAME_W-1:0] cmd_to_send,
    output logic               strobe_out,
    input  logic               ack_in,
    output logic               idle_out,
    output logic               no_response_out,
    input  logic               strobe_in,
    output logic               ack_out,
    input  logic [RESP_W-1:0]  response_in,
    input  logic               command_timeout_in
);

    state_t              r_state;
    state_t              w_next_state;
    logic [FRAME_W-1:0]  r_frame;
    logic [RESP_W-1:0]   r_response;
    logic                r_no_resp;
    logic                r_busy;
    logic                r_strobe;
    logic                r_ack;
    logic                r_complete;
    logic                r_timeout;
    logic                r_idle;
    logic                w_capture;
    logic                w_wd_clear;
    logic                w_wd_enable;
    logic                w_wd_expired;
    logic                w_retry_ok;

    assign w_capture   = (r_state == IDLE) && new_command;
    // Any state change restarts the watchdog, so each wait gets a full budget.
    assign w_wd_clear  = (w_next_state != r_state);
    assign w_wd_enable = (r_state == SEND) || (r_state == RELEASE) ||
                         (r_state == WAIT_RESP) || (r_state == ACK_RESP);

    cmd_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk     (sd_clock),
        .i_reset   (reset),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_enable),
        .o_expired (w_wd_expired)
    );

`ifdef CMD_RETRY_EN
    localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    logic [RETRY_W-1:0] r_retry_count;

    assign w_retry_ok = (r_retry_count < RETRY_W'(MAX_RETRIES));

    // Retry bookkeeping: cleared per command, bumped on each response re-send.
    always_ff @(posedge sd_clock) begin
        if (reset) begin
            r_retry_count <= {RETRY_W{1'b0}};
        end else if (w_capture) begin
            r_retry_count <= {RETRY_W{1'b0}};
        end else if ((r_state == WAIT_RESP) && (w_next_state == SEND)) begin
            r_retry_count <= r_retry_count + 1'b1;
        end else begin
            r_retry_count <= r_retry_count;
        end
    end
`else
    // Retries compiled out; the parameter stays so both builds share one
    // parameter list.
    assign w_retry_ok = 1'b0 & (MAX_RETRIES > 0);
`endif

    // Next-state decode; a response strobe outranks a simultaneous timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (new_command) w_next_state = SEND;
                else             w_next_state = IDLE;
            end
            SEND: begin
                if (ack_in)            w_next_state = RELEASE;
                else if (w_wd_expired) w_next_state = FAIL;
                else                   w_next_state = SEND;
            end
            RELEASE: begin
                if (!ack_in)           w_next_state = r_no_resp ? DONE : WAIT_RESP;
                else if (w_wd_expired) w_next_state = FAIL;
                else                   w_next_state = RELEASE;
            end
            WAIT_RESP: begin
                if (strobe_in)                               w_next_state = ACK_RESP;
                else if (command_timeout_in || w_wd_expired) w_next_state = w_retry_ok ? SEND : FAIL;
                else                                         w_next_state = WAIT_RESP;
            end
            ACK_RESP: begin
                if (!strobe_in)        w_next_state = DONE;
                else if (w_wd_expired) w_next_state = FAIL;
                else                   w_next_state = ACK_RESP;
            end
            DONE:    w_next_state = IDLE;
            FAIL:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge sd_clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Frame/flag capture and response latch.
    always_ff @(posedge sd_clock) begin
        if (reset) begin
            r_frame    <= {FRAME_W{1'b0}};
            r_no_resp  <= 1'b0;
            r_response <= {RESP_W{1'b0}};
        end else begin
            if (w_capture) begin
                r_frame   <= build_frame(cmd_index, cmd_argument);
                r_no_resp <= no_response_req;
            end else begin
                r_frame   <= r_frame;
                r_no_resp <= r_no_resp;
            end
            if ((r_state == WAIT_RESP) && strobe_in) r_response <= response_in;
            else                                     r_response <= r_response;
        end
    end

    // Registered Moore outputs, decoded from the state being entered.
    always_ff @(posedge sd_clock) begin
        if (reset) begin
            r_busy     <= 1'b0;
            r_strobe   <= 1'b0;
            r_ack      <= 1'b0;
            r_complete <= 1'b0;
            r_timeout  <= 1'b0;
            r_idle     <= 1'b1;
        end else begin
            r_busy     <= (w_next_state == SEND) || (w_next_state == RELEASE) ||
                          (w_next_state == WAIT_RESP) || (w_next_state == ACK_RESP);
            r_strobe   <= (w_next_state == SEND);
            r_ack      <= (w_next_state == ACK_RESP);
            r_complete <= (w_next_state == DONE);
            r_timeout  <= (w_next_state == FAIL);
            r_idle     <= (w_next_state == IDLE);
        end
    end

    assign busy             = r_busy;
    assign command_complete = r_complete;
    assign timeout_error    = r_timeout;
    assign response_out     = r_response;
    assign cmd_to_send      = r_frame;
    assign strobe_out       = r_strobe;
    assign idle_out         = r_idle;
    assign no_response_out  = r_no_resp;
    assign ack_out          = r_ack;

endmodule

// File: tb/tb_sd_cmd_transaction.sv
// ----------------------------------------------------------------------------
// tb_sd_cmd_transaction
// Directed bench for sd_cmd_transaction with a small PHY model driven from
// the stimulus process. Expected completion/error events are queued when a
// command is issued; a negedge monitor pops and compares them whenever the
// DUT pulses command_complete or timeout_error.
// ----------------------------------------------------------------------------
module tb_sd_cmd_transaction;

    logic        sd_clock = 1'b0;
    logic        reset = 1'b1;
    logic        new_command = 1'b0;
    logic [5:0]  cmd_index = 6'd0;
    logic [31:0] cmd_argument = 32'd0;
    logic        no_response_req = 1'b0;
    logic        busy, command_complete, timeout_error;
    logic [14:0] response_out;
    logic [39:0] cmd_to_send;
    logic        strobe_out;
    logic        ack_in = 1'b0;
    logic        idle_out, no_response_out;
    logic        strobe_in = 1'b0;
    logic        ack_out;
    logic [14:0] response_in = 15'd0;
    logic        command_timeout_in = 1'b0;

    sd_cmd_transaction #(.TIMEOUT_CYCLES(16), .MAX_RETRIES(2)) dut (
        .sd_clock(sd_clock), .reset(reset), .new_command(new_command),
        .cmd_index(cmd_index), .cmd_argument(cmd_argument),
        .no_response_req(no_response_req), .busy(busy),
        .command_complete(command_complete), .timeout_error(timeout_error),
        .response_out(response_out), .cmd_to_send(cmd_to_send),
        .strobe_out(strobe_out), .ack_in(ack_in), .idle_out(idle_out),
        .no_response_out(no_response_out), .strobe_in(strobe_in),
        .ack_out(ack_out), .response_in(response_in),
        .command_timeout_in(command_timeout_in)
    );

    always #5 sd_clock = ~sd_clock;

    typedef struct packed {
        logic        is_err;
        logic [14:0] resp;
        logic [39:0] frame;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_pulses = 0;
    int   n_strobe_rise = 0;
    logic ack_seen = 1'b0;
    logic prev_strobe = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge sd_clock);
        #1;
    endtask

    function automatic logic get_sig(input int sel);
        case (sel)
            0:       return strobe_out;
            1:       return ack_out;
            2:       return idle_out;
            default: return busy;
        endcase
    endfunction

    // Bounded wait for a DUT output to reach a value; an expired bound counts as a failure.
    task automatic wait_sig(input int sel, input logic val, input string name);
        for (int i = 0; i < 64; i++) begin
            if (get_sig(sel) === val) return;
            cyc();
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired, signal still 0x%0h, expected 0x%0h", name, get_sig(sel), val);
    endtask

    task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic nores);
        cmd_index = idx;
        cmd_argument = arg;
        no_response_req = nores;
        new_command = 1'b1;
        cyc();
        new_command = 1'b0;
    endtask

    // Monitor: scoreboard pops on every completion/error pulse.
    always @(negedge sd_clock) begin
        if (strobe_out && !prev_strobe) n_strobe_rise++;
        prev_strobe = strobe_out;
        if (ack_out) ack_seen = 1'b1;
        if (command_complete || timeout_error) begin
            n_pulses++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: complete=%0b error=%0b with no expected event",
                         command_complete, timeout_error);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_complete", {63'd0, command_complete}, {63'd0, ~e.is_err});
                chk("sb_error", {63'd0, timeout_error}, {63'd0, e.is_err});
                chk("sb_response", {49'd0, response_out}, {49'd0, e.resp});
                chk("sb_frame", {24'd0, cmd_to_send}, {24'd0, e.frame});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int exp_attempts;
        int cnt;
        int pc;
        `ifdef CMD_RETRY_EN
        exp_attempts = 3;
        `else
        exp_attempts = 1;
        `endif

        // Reset values
        cyc(); cyc(); cyc();
        chk("rst_idle", {63'd0, idle_out}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_strobe", {63'd0, strobe_out}, 64'd0);
        chk("rst_ack", {63'd0, ack_out}, 64'd0);
        chk("rst_frame", {24'd0, cmd_to_send}, 64'd0);
        chk("rst_resp", {49'd0, response_out}, 64'd0);
        chk("rst_pulses", {62'd0, command_complete, timeout_error}, 64'd0);
        reset = 1'b0;
        cyc();

        // T1: index 17, arg 0x1234, PHY acks after 2 cycles, response 0x5A5A
        sb.push_back('{is_err: 1'b0, resp: 15'h5A5A, frame: 40'h51_0000_1234});
        issue(6'd17, 32'h0000_1234, 1'b0);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        chk("t1_frame", {24'd0, cmd_to_send}, 64'h51_0000_1234);
        chk("t1_strobe", {63'd0, strobe_out}, 64'd1);
        cyc(); cyc();
        ack_in = 1'b1;
        wait_sig(0, 1'b0, "t1_strobe_lo");
        ack_in = 1'b0;
        cyc(); cyc();
        response_in = 15'h5A5A;
        strobe_in = 1'b1;
        wait_sig(1, 1'b1, "t1_ack_hi");
        strobe_in = 1'b0;
        wait_sig(2, 1'b1, "t1_idle");
        chk("t1_resp", {49'd0, response_out}, 64'h5A5A);
        chk("t1_busy_low", {63'd0, busy}, 64'd0);

        // T2: no response expected, index 0 arg 0
        sb.push_back('{is_err: 1'b0, resp: 15'h5A5A, frame: 40'h40_0000_0000});
        ack_seen = 1'b0;
        issue(6'd0, 32'h0, 1'b1);
        chk("t2_nores", {63'd0, no_response_out}, 64'd1);
        chk("t2_frame", {24'd0, cmd_to_send}, 64'h40_0000_0000);
        ack_in = 1'b1;
        wait_sig(0, 1'b0, "t2_strobe_lo");
        ack_in = 1'b0;
        wait_sig(2, 1'b1, "t2_idle");
        chk("t2_no_ack_out", {63'd0, ack_seen}, 64'd0);

        // T3: PHY response timeout in WAIT_RESP
        sb.push_back('{is_err: 1'b1, resp: 15'h5A5A, frame: 40'h45_DEAD_BEEF});
        n_strobe_rise = 0;
        issue(6'd5, 32'hDEAD_BEEF, 1'b0);
        for (int a = 0; a < exp_attempts; a++) begin
            wait_sig(0, 1'b1, "t3_strobe_hi");
            ack_in = 1'b1;
            wait_sig(0, 1'b0, "t3_strobe_lo");
            ack_in = 1'b0;
            cyc();
            command_timeout_in = 1'b1;
            cyc();
            command_timeout_in = 1'b0;
        end
        wait_sig(2, 1'b1, "t3_idle");
        cyc();
        chk("t3_strobe_count", n_strobe_rise, exp_attempts);
        chk("t3_resp_held", {49'd0, response_out}, 64'h5A5A);

        // T4: ack never arrives; watchdog (16 cycles) fires from SEND
        sb.push_back('{is_err: 1'b1, resp: 15'h5A5A, frame: 40'h49_0000_00FF});
        issue(6'd9, 32'h0000_00FF, 1'b0);
        cnt = 0;
        while (!timeout_error && cnt < 40) begin
            cyc();
            cnt++;
        end
        chk("t4_wd_latency", cnt, 16);
        chk("t4_strobe_low", {63'd0, strobe_out}, 64'd0);
        wait_sig(2, 1'b1, "t4_idle");

        // T5: reset while in ACK_RESP
        issue(6'd2, 32'h0000_0011, 1'b0);
        ack_in = 1'b1;
        wait_sig(0, 1'b0, "t5_strobe_lo");
        ack_in = 1'b0;
        cyc();
        response_in = 15'h1111;
        strobe_in = 1'b1;
        wait_sig(1, 1'b1, "t5_ack_hi");
        pc = n_pulses;
        reset = 1'b1;
        cyc();
        chk("t5_idle", {63'd0, idle_out}, 64'd1);
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_ack_out", {63'd0, ack_out}, 64'd0);
        chk("t5_resp_cleared", {49'd0, response_out}, 64'd0);
        strobe_in = 1'b0;
        cyc();
        reset = 1'b0;
        cyc(); cyc();
        chk("t5_no_pulse", n_pulses, pc);

        // T6: second request while busy; strobe_in and timeout together
        sb.push_back('{is_err: 1'b0, resp: 15'h0ABC, frame: 40'h48_CAFE_0001});
        issue(6'd8, 32'hCAFE_0001, 1'b0);
        cmd_index = 6'd63;
        cmd_argument = 32'hFFFF_FFFF;
        new_command = 1'b1;
        cyc();
        new_command = 1'b0;
        ack_in = 1'b1;
        wait_sig(0, 1'b0, "t6_strobe_lo");
        ack_in = 1'b0;
        cyc();
        response_in = 15'h0ABC;
        strobe_in = 1'b1;
        command_timeout_in = 1'b1;
        cyc();
        command_timeout_in = 1'b0;
        wait_sig(1, 1'b1, "t6_ack_hi");
        strobe_in = 1'b0;
        wait_sig(2, 1'b1, "t6_idle");
        cyc();
        chk("t6_frame_kept", {24'd0, cmd_to_send}, 64'h48_CAFE_0001);
        chk("t6_resp", {49'd0, response_out}, 64'h0ABC);
        cyc(); cyc();
        chk("t6_still_idle", {63'd0, idle_out}, 64'd1);

        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
